// File: rtl/xs3_to_bcd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : xs3_to_bcd_decoder
// Purpose  : Converts a packed word of Excess-3 digits to packed BCD, one
//            digit per clock, with per-digit invalid-code flags and a
//            valid/ready handshake on both sides.
// Revision : 1.0  initial release
// ============================================================================
module xs3_to_bcd_decoder #(
  parameter int NDIGITS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NDIGITS-1:0]   in_xs3,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NDIGITS-1:0]   out_bcd,
  output logic [NDIGITS-1:0]     out_err_mask,
  output logic                   out_err
);

  // Index width kept at least one bit so NDIGITS=1 still elaborates.
  localparam int IDXW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(NDIGITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                 state_q,     state_d;
  logic [IDXW-1:0]        idx_q,       idx_d;
  logic [4*NDIGITS-1:0]   word_q,      word_d;
  logic [4*NDIGITS-1:0]   bcd_q,       bcd_d;
  logic [NDIGITS-1:0]     mask_q,      mask_d;
  logic                   err_q,       err_d;
  logic                   in_ready_q,  in_ready_d;
  logic                   out_valid_q, out_valid_d;

  logic [3:0]             w_cur_code;
  logic [3:0]             w_dig_bcd;
  logic                   w_dig_err;

  // Select the captured digit addressed by the current index.
  always_comb begin
    w_cur_code = 4'h0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (idx_q == IDXW'(i)) begin
        w_cur_code = word_q[4*i +: 4];
      end
    end
  end

  // Single-digit decode: 3..12 map to 0..9, every other code is flagged.
  always_comb begin
    if ((w_cur_code >= 4'h3) && (w_cur_code <= 4'hC)) begin
      w_dig_bcd = w_cur_code - 4'h3;
      w_dig_err = 1'b0;
    end else begin
      w_dig_bcd = 4'hF;
      w_dig_err = 1'b1;
    end
  end

  // Next-state and next-output computation for the IDLE/CONV/DONE sequencer.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    word_d      = word_q;
    bcd_d       = bcd_q;
    mask_d      = mask_q;
    err_d       = err_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          word_d     = in_xs3;
          idx_d      = '0;
          bcd_d      = '0;
          mask_d     = '0;
          err_d      = 1'b0;
          in_ready_d = 1'b0;
          state_d    = ST_CONV;
        end
      end

      ST_CONV: begin
        // Write the decoded digit into its own lane; other lanes keep value.
        for (int i = 0; i < NDIGITS; i++) begin
          if (idx_q == IDXW'(i)) begin
            bcd_d[4*i +: 4] = w_dig_bcd;
            mask_d[i]       = w_dig_err;
          end
        end
        err_d = err_q | w_dig_err;
        if (idx_q == C_LAST_IDX) begin
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end

      ST_DONE: begin
        // in_ready stays low here, so a word offered in this cycle is ignored.
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      word_q      <= '0;
      bcd_q       <= '0;
      mask_q      <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      bcd_q       <= bcd_d;
      mask_q      <= mask_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_bcd      = bcd_q;
  assign out_err_mask = mask_q;
  assign out_err      = err_q;

endmodule
`default_nettype wire
